// File: rtl/axis_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_tx_arbiter
// Description : Two-source round-robin AXI4-Stream arbiter that feeds the UART
//               transmit FIFO. The grant is held until frame end or burst limit.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_tx_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    input  logic                  s0_axis_tlast,
    output logic                  s0_axis_tready,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    input  logic                  s1_axis_tlast,
    output logic                  s1_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [1:0]            grant,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    localparam logic [7:0] C_BURST_LAST = 8'(MAX_BURST - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last_grant;
    logic [7:0] r_beat_cnt;
    logic       w_xfer;
    logic       w_release;

    // Output mux depends only on state, so m_axis_tready never reaches a tvalid.
    always_comb begin
        m_axis_tdata   = '0;
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        case (r_state)
            ST_GRANT0: begin
                m_axis_tdata   = s0_axis_tdata;
                m_axis_tvalid  = s0_axis_tvalid;
                m_axis_tlast   = s0_axis_tlast;
                s0_axis_tready = m_axis_tready;
            end
            ST_GRANT1: begin
                m_axis_tdata   = s1_axis_tdata;
                m_axis_tvalid  = s1_axis_tvalid;
                m_axis_tlast   = s1_axis_tlast;
                s1_axis_tready = m_axis_tready;
            end
            default: ;
        endcase
    end

    assign grant     = {r_state == ST_GRANT1, r_state == ST_GRANT0};
    assign busy      = |grant;
    assign w_xfer    = m_axis_tvalid && m_axis_tready && rst_n;
    assign w_release = w_xfer && (m_axis_tlast || (r_beat_cnt == C_BURST_LAST));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                // On a tie the source that did not hold the last grant wins.
                if (s0_axis_tvalid && (!s1_axis_tvalid || r_last_grant)) begin
                    w_state_nxt = ST_GRANT0;
                end else if (s1_axis_tvalid) begin
                    w_state_nxt = ST_GRANT1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_beat_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE) begin
                r_beat_cnt <= '0;
                if (w_state_nxt == ST_GRANT0) begin
                    r_last_grant <= 1'b0;
                end else if (w_state_nxt == ST_GRANT1) begin
                    r_last_grant <= 1'b1;
                end
            end else if (w_xfer) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire
